// File: rtl/dm_pkg.sv
// Shared types and default widths for the data-memory access blocks.
package dm_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned DM_ADDRESS_LINE = 8;
    localparam int unsigned DM_LEN_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } dm_state_e;

endpackage

// File: rtl/dm_rd_skid.sv
// One-entry read output register: captures a memory byte when empty or being drained,
// so a consumer with rd_ready held high sees one byte per clock.
module dm_rd_skid
    import dm_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         rd_ready,
    output logic         cap,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);

    assign cap = !rd_valid || rd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (load && cap) begin
            rd_valid <= 1'b1;
            rd_data  <= load_data;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dm_burst_ctrl.sv
// Burst access controller for the 256x8 data memory: one request at a time, write bytes
// streamed in through wr_valid/wr_ready, read bytes streamed out through rd_valid/rd_ready.
module dm_burst_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned ADDRESS_LINE = DM_ADDRESS_LINE,
    parameter int unsigned LEN_W        = DM_LEN_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDRESS_LINE-1:0] req_addr,
    input  logic [LEN_W-1:0]        req_len,
    input  logic                    wr_valid,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ready,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    input  logic                    rd_ready,
    output logic                    burst_done,
    output logic                    busy,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic [DATA_W-1:0]       mem_write_data,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [DATA_W-1:0]       mem_read_data
);

    dm_state_e               state;
    logic [ADDRESS_LINE-1:0] addr_q;
    logic [LEN_W-1:0]        beats_q;
    logic                    cap;
    logic                    take_wr;
    logic                    take_rd;
    logic                    beat;

    assign take_wr = (state == WRITE) && wr_valid;
    assign take_rd = (state == READ) && cap;
    assign beat    = take_wr || take_rd;

    assign req_ready      = (state == IDLE);
    assign wr_ready       = (state == WRITE);
    assign busy           = (state != IDLE);
    assign mem_address    = addr_q;
    assign mem_write_data = wr_data;
    assign mem_write      = take_wr;
    assign mem_read       = (state == READ);

    // A read byte left over from the previous burst simply holds off the first capture.
    dm_rd_skid #(
        .W(DATA_W)
    ) u_rd_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (state == READ),
        .load_data(mem_read_data),
        .rd_ready (rd_ready),
        .cap      (cap),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        beats_q <= req_len;
                        state   <= req_write ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    if (beat) begin
                        addr_q  <= addr_q + 1'b1;
                        beats_q <= beats_q - 1'b1;
                        if (beats_q == '0) begin
                            state      <= IDLE;
                            burst_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_burst_ctrl.sv
// Self-checking bench for dm_burst_ctrl with an attached 256x8 memory and a read scoreboard.
module tb_dm_burst_ctrl;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [3:0] req_len;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic       burst_done;
    logic       busy;
    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] mem_read_data;

    logic [7:0] mem[256];
    logic [7:0] ref_mem[256];
    logic [7:0] exp_q[$];
    logic [7:0] wdata[4];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt = 0;
    int         d0;

    dm_burst_ctrl #(
        .ADDRESS_LINE(8),
        .LEN_W       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .burst_done    (burst_done),
        .busy          (busy),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_read_data (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with its power-on image: address 0 holds 0xFF, everything else 0x00.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem[0]     = 8'hFF;
        ref_mem[0] = 8'hFF;
    end
    always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;
    assign mem_read_data = mem[mem_address];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (burst_done) done_cnt++;
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("rd_extra", 32'(rd_valid), 32'd0);
                end else begin
                    check_eq("rd_data", 32'(rd_data), 32'(exp_q[0]));
                    if (rd_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_read(input logic [7:0] addr, input logic [3:0] len);
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(ref_mem[8'(addr + 8'(i))]);
    endtask

    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [3:0] len);
        logic ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("req_accept", 32'(ok), 32'd1);
        if (!wr) push_read(addr, len);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic write_beats(input logic [7:0] addr, input int n, input int gap_at);
        logic ok;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                wr_valid = 1'b0;
                @(negedge clk);
                check_eq("gap_no_write", 32'(mem_write), 32'd0);
                check_eq("gap_busy", 32'(busy), 32'd1);
                @(posedge clk);
                #1;
            end
            wr_valid = 1'b1;
            wr_data  = wdata[i];
            ok       = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (wr_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check_eq("wr_accept", 32'(ok), 32'd1);
            ref_mem[8'(addr + 8'(i))] = wdata[i];
            @(posedge clk);
            #1 wr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy && !rd_valid && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("idle_reached", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        logic phase;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_burst_done", 32'(burst_done), 32'd0);
        check_eq("rst_mem_ctl", 32'({mem_write, mem_read, wr_ready}), 32'd0);
        check_eq("rst_mem_address", 32'(mem_address), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Read the power-on image: 0xFF then 0x00 on back-to-back cycles.
        d0 = done_cnt;
        do_req(1'b0, 8'h00, 4'd1);
        @(negedge clk);
        check_eq("rd1_lat_v0", 32'(rd_valid), 32'd0);
        check_eq("rd1_mem_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        check_eq("rd1_v1", 32'(rd_valid), 32'd1);
        @(negedge clk);
        check_eq("rd1_v2", 32'(rd_valid), 32'd1);
        check_eq("rd1_done", 32'(burst_done), 32'd1);
        check_eq("rd1_busy", 32'(busy), 32'd0);
        wait_idle();
        check_eq("rd1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Wrapping write burst with a one-cycle gap after the second beat.
        d0 = done_cnt;
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        do_req(1'b1, 8'hFE, 4'd3);
        write_beats(8'hFE, 4, 2);
        wait_idle();
        check_eq("wr_mem_fe", 32'(mem[8'hFE]), 32'h11);
        check_eq("wr_mem_ff", 32'(mem[8'hFF]), 32'h22);
        check_eq("wr_mem_00", 32'(mem[8'h00]), 32'h33);
        check_eq("wr_mem_01", 32'(mem[8'h01]), 32'h44);
        check_eq("wr_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Read it back with the consumer stalled for three cycles on the first byte.
        d0 = done_cnt;
        rd_ready = 1'b0;
        do_req(1'b0, 8'hFE, 4'd3);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("stall_valid_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("stall_hold", 32'(rd_data), 32'h11);
        end
        @(posedge clk);
        #1 rd_ready = 1'b1;
        wait_idle();
        check_eq("stall_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Single-beat write immediately followed by a read of the same byte.
        d0 = done_cnt;
        wdata[0] = 8'hA5;
        do_req(1'b1, 8'h10, 4'd0);
        write_beats(8'h10, 1, -1);
        do_req(1'b0, 8'h10, 4'd0);
        wait_idle();
        check_eq("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);

        // Reset in the middle of a write burst.
        d0 = done_cnt;
        wdata[0] = 8'h5A; wdata[1] = 8'h6B;
        do_req(1'b1, 8'h20, 4'd3);
        write_beats(8'h20, 2, -1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h7C;
        @(negedge clk);
        check_eq("abort_req_ready", 32'(req_ready), 32'd1);
        check_eq("abort_mem_write", 32'(mem_write), 32'd0);
        check_eq("abort_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("abort_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        check_eq("abort_mem_20", 32'(mem[8'h20]), 32'h5A);
        check_eq("abort_mem_21", 32'(mem[8'h21]), 32'h6B);
        check_eq("abort_mem_22", 32'(mem[8'h22]), 32'h00);
        check_eq("abort_done_cnt", 32'(done_cnt - d0), 32'd0);

        // req_valid held across a burst: second request waits for the burst_done cycle.
        d0 = done_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'hFE; req_len = 4'd3;
        phase = 1'b0;
        ok    = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!phase) begin
                if (req_ready) begin
                    push_read(8'hFE, 4'd3);
                    phase = 1'b1;
                    @(posedge clk);
                    #1 req_addr = 8'h10; req_len = 4'd0;
                end
            end else if (busy) begin
                check_eq("held_req_blocked", 32'(req_ready), 32'd0);
            end else if (req_ready) begin
                check_eq("held_accept_on_done", 32'(burst_done), 32'd1);
                push_read(8'h10, 4'd0);
                ok = 1'b1;
                @(posedge clk);
                #1 req_valid = 1'b0;
                break;
            end
        end
        check_eq("held_second_accept", 32'(ok), 32'd1);
        req_valid = 1'b0;
        wait_idle();
        check_eq("held_done_cnt", 32'(done_cnt - d0), 32'd2);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check_eq("total_done_cnt", 32'(done_cnt), 32'd7);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_burst_ctrl.md
Name: dm_burst_ctrl

Overview:
- Upstream access controller for the 256x8 data memory block.
- Accepts one burst request at a time: a start address, a beat count and a direction.
- Streams write bytes into memory, or streams read bytes out of memory, through valid/ready handshakes.
- Drives the memory's address, write_data, mem_write and mem_read directly; memory reads are combinational and writes commit on posedge clk.

Parameters:
ADDRESS_LINE, 8, memory address width; addresses wrap modulo 2^ADDRESS_LINE
LEN_W, 4, burst length field width; a burst is req_len+1 beats (1..16)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-high
req_valid  input  1  burst request offered
req_ready  output  1  controller idle, request accepted when req_valid&&req_ready
req_write  input  1  1=write burst, 0=read burst
req_addr  input  ADDRESS_LINE  burst start address
req_len  input  LEN_W  beats minus one
wr_valid  input  1  write byte offered
wr_data  input  8  write byte
wr_ready  output  1  write byte accepted when wr_valid&&wr_ready
rd_valid  output  1  read byte available
rd_data  output  8  read byte
rd_ready  input  1  consumer takes rd_data when rd_valid&&rd_ready
burst_done  output  1  one-cycle pulse after final beat of a burst
busy  output  1  burst in progress (state!=IDLE)
mem_address  output  ADDRESS_LINE  to memory address
mem_write_data  output  8  to memory write_data
mem_write  output  1  to memory mem_write
mem_read  output  1  to memory mem_read
mem_read_data  input  8  from memory read_data

Behaviour:
- Reset (sync, active-high): state=IDLE; addr_q=0, beats_q=0; rd_valid=0, rd_data=0; burst_done=0; busy=0; mem_write=0, mem_read=0. Reset mid-burst aborts immediately; beats already written stay in memory, and a held read byte is dropped.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - req_ready=1.
  - On accept: addr_q=req_addr, beats_q=req_len; go to WRITE if req_write, else READ.
  - A request is accepted even while rd_valid=1 from the prior burst; the READ stalls until that byte drains.
- WRITE:
  - wr_ready=1; mem_address=addr_q; mem_write_data=wr_data; mem_write=wr_valid (combinational).
  - Each accepted beat commits at that posedge.
  - On each accepted beat: addr_q+=1 (wraps 0xFF->0x00); beats_q-=1.
  - On the beat where beats_q==0: go to IDLE and pulse burst_done next cycle.
  - wr_valid low: no write and no advance (stall, any duration).
- READ:
  - mem_address=addr_q; mem_read=1; capture condition cap = !rd_valid || rd_ready.
  - On cap: rd_data<=mem_read_data, rd_valid<=1, addr_q+=1 (wrap), beats_q-=1.
  - On cap with beats_q==0: go to IDLE and pulse burst_done next cycle.
  - Without cap: hold everything. rd_data must not change while rd_valid&&!rd_ready.
- Output register (all states):
  - rd_valid&&rd_ready with no new capture clears rd_valid.
  - Capture and consume in the same cycle keeps rd_valid=1 with the new byte, giving full throughput of one beat per clk.
- Latency:
  - Write: a beat accepted at edge N is visible to a memory read in cycle N+1.
  - Read: rd_valid rises one cycle after entering READ.
- Control signals:
  - wr_ready=0 outside WRITE.
  - mem_write=0 and mem_read=0 outside their states.
  - mem_address=addr_q always.
  - busy=(state!=IDLE). burst_done is never asserted together with req acceptance of the same burst.
- Read-after-write ordering is guaranteed because bursts are strictly serialised.

Decomposition:
- Shared package dm_pkg holds:
  - State enum (IDLE/WRITE/READ)
  - DATA_W=8
  - Default ADDRESS_LINE and LEN_W constants
- Sub-module dm_rd_skid holds the one-entry read output register with the cap/consume logic. It is reusable by other memory readers.
- Address/beat counters and the FSM stay in the top.

Test Plan:
- Memory at reset contents (addr0=0xFF, others 0x00); read burst addr=0x00 len=1, rd_ready=1 -> rd_data 0xFF then 0x00 on consecutive cycles; burst_done pulses once; busy returns 0.
- Write burst addr=0xFE len=3, data 0x11,0x22,0x33,0x44 with wr_valid gap after beat 2 -> memory 0xFE=0x11, 0xFF=0x22, 0x00=0x33, 0x01=0x44 (wrap). No write during gap.
- Read burst addr=0xFE len=3 with rd_ready low for 3 cycles after the first byte -> rd_data held at 0x11 during stall; then 0x22,0x33,0x44; no beat lost or duplicated.
- Back-to-back: write len=0 addr=0x10 data 0xA5, then read len=0 addr=0x10 issued the cycle after burst_done -> rd_data=0xA5.
- Reset asserted mid write burst (after 2 of 4 beats, addr=0x20) -> next cycle state=IDLE, req_ready=1, mem_write=0, rd_valid=0. Memory 0x20/0x21 hold written values, 0x22 is untouched.
- req_valid held while busy -> req_ready=0 throughout; second request accepted only in the cycle after burst_done returns state to IDLE.
